ps2_key_sequencer: RTL and testbench

//  Consumes scan-code bytes from the ps2_keyboard FIFO, drives its nextdata_n pop strobe and

---
 rtl/ps2_pkg.sv | 16 +
 rtl/ps2_prefix_timer.sv | 35 +++
 rtl/ps2_key_sequencer.sv | 148 ++++++++++++++
 tb/tb_ps2_key_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 key sequencer.
package ps2_pkg;

   typedef enum logic {IDLE, ACK} ps2_state_e;

   localparam logic [7:0] PS2_BRK  = 8'hF0;
   localparam logic [7:0] PS2_EXT  = 8'hE0;
   localparam logic [7:0] PS2_ERR0 = 8'h00;
   localparam logic [7:0] PS2_ERR1 = 8'hFF;

   typedef struct packed {
      logic       ext;
      logic [7:0] code;
   } ps2_key_t;

endpackage

// File: rtl/ps2_prefix_timer.sv
// Idle timer for pending F0/E0 prefixes: reloads on every captured byte,
// counts down while enabled and pulses expire for one cycle on reaching zero.
module ps2_prefix_timer #(
   parameter int unsigned TO_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int unsigned W = $clog2(TO_CYCLES + 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         expire <= 1'b0;
      end else begin
         expire <= 1'b0;
         if (load) begin
            cnt <= W'(TO_CYCLES);
         end else if (clr) begin
            cnt <= '0;
         end else if (en && cnt != '0) begin
            cnt    <= cnt - W'(1);
            expire <= (cnt == W'(1));
         end
      end
   end

endmodule

// File: rtl/ps2_key_sequencer.sv
// Pops scan-code bytes from the ps2_keyboard FIFO and turns set-2 make/break/extended
// sequences into single key events with held-key tracking and a press counter.
module ps2_key_sequencer
   import ps2_pkg::*;
#(
   parameter int unsigned CNT_W         = 8,
   parameter int unsigned TO_CYCLES     = 1000000,
   parameter bit          REPEAT_FILTER = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ready,
   input  logic [7:0]       data,
   input  logic             overflow,
   input  logic             err_clr,
   output logic             nextdata_n,
   output logic             key_valid,
   output logic [7:0]       key_code,
   output logic             key_ext,
   output logic             key_make,
   output logic             key_down,
   output logic [CNT_W-1:0] press_cnt,
   output logic             err_ovf
);

   ps2_state_e       state, state_d;
   logic [7:0]       byte_q, byte_d;
   logic             brk_pend, brk_d, ext_pend, ext_d;
   logic             valid_d, kext_d, make_d, down_d, err_d;
   logic [7:0]       code_d;
   logic [CNT_W-1:0] cnt_d;
   ps2_key_t         held_q, held_d, cur;
   logic             capture, tmr_expire;

   assign cur = {ext_pend, byte_q};

   ps2_prefix_timer #(.TO_CYCLES(TO_CYCLES)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (capture),
      .clr    (overflow),
      .en     (brk_pend | ext_pend),
      .expire (tmr_expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         byte_q     <= '0;
         brk_pend   <= 1'b0;
         ext_pend   <= 1'b0;
         held_q     <= '0;
         nextdata_n <= 1'b1;
         key_valid  <= 1'b0;
         key_code   <= '0;
         key_ext    <= 1'b0;
         key_make   <= 1'b0;
         key_down   <= 1'b0;
         press_cnt  <= '0;
         err_ovf    <= 1'b0;
      end else begin
         state      <= state_d;
         byte_q     <= byte_d;
         brk_pend   <= brk_d;
         ext_pend   <= ext_d;
         held_q     <= held_d;
         nextdata_n <= (state_d != ACK);
         key_valid  <= valid_d;
         key_code   <= code_d;
         key_ext    <= kext_d;
         key_make   <= make_d;
         key_down   <= down_d;
         press_cnt  <= cnt_d;
         err_ovf    <= err_d;
      end
   end

   always_comb begin
      state_d = state;
      byte_d  = byte_q;
      brk_d   = brk_pend;
      ext_d   = ext_pend;
      held_d  = held_q;
      valid_d = 1'b0;
      code_d  = key_code;
      kext_d  = key_ext;
      make_d  = key_make;
      down_d  = key_down;
      cnt_d   = press_cnt;
      err_d   = err_ovf & ~err_clr;
      capture = 1'b0;
      case (state)
         IDLE: begin
            if (ready) begin
               capture = 1'b1;
               byte_d  = data;
               state_d = ACK;
            end
         end
         ACK: begin
            state_d = IDLE;
            // overflow in the pop cycle discards the byte entirely
            if (!overflow) begin
               if (byte_q == PS2_BRK) begin
                  brk_d = 1'b1;
               end else if (byte_q == PS2_EXT) begin
                  ext_d = 1'b1;
               end else if (byte_q == PS2_ERR0 || byte_q == PS2_ERR1) begin
                  brk_d = 1'b0;
                  ext_d = 1'b0;
                  err_d = 1'b1;
               end else begin
                  brk_d = 1'b0;
                  ext_d = 1'b0;
                  if (!brk_pend) begin
                     if (!(REPEAT_FILTER && key_down && held_q == cur)) begin
                        valid_d = 1'b1;
                        code_d  = byte_q;
                        kext_d  = ext_pend;
                        make_d  = 1'b1;
                        down_d  = 1'b1;
                        held_d  = cur;
                        cnt_d   = press_cnt + CNT_W'(1);
                     end
                  end else begin
                     valid_d = 1'b1;
                     code_d  = byte_q;
                     kext_d  = ext_pend;
                     make_d  = 1'b0;
                     if (key_down && held_q == cur) down_d = 1'b0;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (tmr_expire) begin
         brk_d = 1'b0;
         ext_d = 1'b0;
      end
      if (overflow) begin
         brk_d = 1'b0;
         ext_d = 1'b0;
         err_d = 1'b1;
      end
   end

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed and randomized bench for ps2_key_sequencer against a byte-level event model,
// with a bench-side FIFO that pops on each low nextdata_n cycle.
module tb_ps2_key_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ready = 1'b0;
   logic [7:0] data = 8'h00;
   logic       overflow = 1'b0;
   logic       err_clr = 1'b0;

   logic       nd[2];
   logic       kv[2];
   logic [7:0] kc[2];
   logic       ke[2];
   logic       km[2];
   logic       kd[2];
   logic [3:0] pc[2];
   logic       eo[2];

   int checks = 0;
   int errors = 0;

   logic [7:0] q[$];

   // model state, index 0 = repeat filter on, 1 = filter off
   logic       m_brk[2], m_ext[2], m_down[2], m_valid[2], m_kext[2], m_make[2], m_err[2];
   logic [8:0] m_held[2];
   logic [7:0] m_code[2];
   int unsigned m_cnt[2];
   int          ev[2];

   always #5 clk = ~clk;

   ps2_key_sequencer #(.CNT_W(4), .TO_CYCLES(16), .REPEAT_FILTER(1'b1)) dut (
      .clk(clk), .rst(rst), .ready(ready), .data(data), .overflow(overflow), .err_clr(err_clr),
      .nextdata_n(nd[0]), .key_valid(kv[0]), .key_code(kc[0]), .key_ext(ke[0]),
      .key_make(km[0]), .key_down(kd[0]), .press_cnt(pc[0]), .err_ovf(eo[0])
   );

   ps2_key_sequencer #(.CNT_W(4), .TO_CYCLES(16), .REPEAT_FILTER(1'b0)) dut0 (
      .clk(clk), .rst(rst), .ready(ready), .data(data), .overflow(overflow), .err_clr(err_clr),
      .nextdata_n(nd[1]), .key_valid(kv[1]), .key_code(kc[1]), .key_ext(ke[1]),
      .key_make(km[1]), .key_down(kd[1]), .press_cnt(pc[1]), .err_ovf(eo[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int f = 0; f < 2; f++) begin
         m_brk[f] = 0; m_ext[f] = 0; m_down[f] = 0; m_valid[f] = 0;
         m_kext[f] = 0; m_make[f] = 0; m_err[f] = 0; m_held[f] = '0;
         m_code[f] = '0; m_cnt[f] = 0;
      end
   endtask

   task automatic model_prefix_clear();
      for (int f = 0; f < 2; f++) begin
         m_brk[f] = 0; m_ext[f] = 0;
      end
   endtask

   task automatic model_ovf();
      model_prefix_clear();
      for (int f = 0; f < 2; f++) m_err[f] = 1;
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic was_brk;
      logic [8:0] k;
      for (int f = 0; f < 2; f++) begin
         if (b == 8'hF0) m_brk[f] = 1;
         else if (b == 8'hE0) m_ext[f] = 1;
         else if (b == 8'h00 || b == 8'hFF) begin
            m_brk[f] = 0; m_ext[f] = 0; m_err[f] = 1;
         end else begin
            was_brk = m_brk[f];
            k = {m_ext[f], b};
            m_brk[f] = 0; m_ext[f] = 0;
            if (!was_brk) begin
               if (!(f == 0 && m_down[f] && m_held[f] == k)) begin
                  m_valid[f] = 1; m_code[f] = b; m_kext[f] = k[8]; m_make[f] = 1;
                  m_down[f] = 1; m_held[f] = k; m_cnt[f] = (m_cnt[f] + 1) % 16;
               end
            end else begin
               m_valid[f] = 1; m_code[f] = b; m_kext[f] = k[8]; m_make[f] = 0;
               if (m_down[f] && m_held[f] == k) m_down[f] = 0;
            end
         end
      end
   endtask

   task automatic drive_fifo();
      ready = (q.size() != 0);
      data  = ready ? q[0] : 8'h00;
   endtask

   task automatic check_all();
      for (int f = 0; f < 2; f++) begin
         chk($sformatf("u%0d.key_valid", f), kv[f], m_valid[f]);
         chk($sformatf("u%0d.key_code", f), kc[f], m_code[f]);
         chk($sformatf("u%0d.key_ext", f), ke[f], m_kext[f]);
         chk($sformatf("u%0d.key_make", f), km[f], m_make[f]);
         chk($sformatf("u%0d.key_down", f), kd[f], m_down[f]);
         chk($sformatf("u%0d.press_cnt", f), pc[f], m_cnt[f]);
         chk($sformatf("u%0d.err_ovf", f), eo[f], m_err[f]);
      end
   endtask

   task automatic tick();
      logic pop, ovf, clr;
      logic [7:0] b;
      pop = (nd[0] === 1'b0);
      ovf = overflow;
      clr = err_clr;
      @(posedge clk);
      #1;
      for (int f = 0; f < 2; f++) m_valid[f] = 0;
      if (clr) for (int f = 0; f < 2; f++) m_err[f] = 0;
      if (pop) begin
         chk("nd_single_cycle", nd[0], 1'b1);
         b = q.pop_front();
         if (ovf) model_ovf();
         else model_byte(b);
      end else if (ovf) begin
         model_ovf();
      end
      drive_fifo();
      check_all();
      for (int f = 0; f < 2; f++) if (kv[f] === 1'b1) ev[f]++;
   endtask

   task automatic push(input logic [7:0] b);
      q.push_back(b);
      drive_fifo();
   endtask

   task automatic drain();
      bit done;
      done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         tick();
         if (q.size() == 0 && nd[0] === 1'b1) done = 1;
      end
      chk("drain_bound", done, 1'b1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      check_all();
      chk("reset_nd", nd[0], 1'b1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] pool[10];
      pool = '{8'h1C, 8'h1B, 8'h23, 8'h75, 8'h6B, 8'h15, 8'hF0, 8'hE0, 8'hF0, 8'h00};
      model_reset();
      ev[0] = 0; ev[1] = 0;
      do_reset();

      // 1) single make, latency and pop pulse
      push(8'h1C);
      tick();
      chk("t1_nd_low", nd[0], 1'b0);
      chk("t1_no_valid_yet", kv[0], 1'b0);
      tick();
      chk("t1_valid", kv[0], 1'b1);
      chk("t1_code", kc[0], 8'h1C);
      chk("t1_make", km[0], 1'b1);
      chk("t1_ext", ke[0], 1'b0);
      chk("t1_down", kd[0], 1'b1);
      chk("t1_cnt", pc[0], 4'd1);
      chk("t1_nd_high", nd[0], 1'b1);

      // 2) break of held key
      ev[0] = 0;
      push(8'hF0); push(8'h1C);
      drain();
      chk("t2_events", ev[0], 1);
      chk("t2_make", km[0], 1'b0);
      chk("t2_down", kd[0], 1'b0);
      chk("t2_cnt", pc[0], 4'd1);

      // 3) typematic repeats, filter on vs off
      do_reset();
      ev[0] = 0; ev[1] = 0;
      push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
      drain();
      chk("t3_events_f1", ev[0], 2);
      chk("t3_events_f0", ev[1], 4);
      chk("t3_cnt_f1", pc[0], 4'd1);
      chk("t3_cnt_f0", pc[1], 4'd3);

      // 4) extended keys and non-matching break
      push(8'hE0); push(8'h75);
      drain();
      chk("t4_ext", ke[0], 1'b1);
      chk("t4_code", kc[0], 8'h75);
      chk("t4_make", km[0], 1'b1);
      push(8'hE0); push(8'hF0); push(8'h75);
      drain();
      chk("t4_brk_make", km[0], 1'b0);
      chk("t4_brk_ext", ke[0], 1'b1);
      chk("t4_brk_down", kd[0], 1'b0);
      push(8'h15);
      drain();
      push(8'hE0); push(8'hF0); push(8'h75);
      drain();
      chk("t4_nomatch_down", kd[0], 1'b1);
      chk("t4_nomatch_make", km[0], 1'b0);

      // 5) prefix still live after a short gap, expired after a long one
      push(8'hF0);
      drain();
      repeat (4) tick();
      push(8'h1C);
      drain();
      chk("t5_live_make", km[0], 1'b0);
      push(8'hF0);
      drain();
      repeat (24) tick();
      model_prefix_clear();
      push(8'h1C);
      drain();
      chk("t5_expired_make", km[0], 1'b1);

      // 6) overflow during ACK drops the byte; err_ovf sticky until err_clr
      push(8'h2D);
      tick();
      chk("t6_in_ack", nd[0], 1'b0);
      overflow = 1'b1;
      tick();
      overflow = 1'b0;
      chk("t6_dropped", kv[0], 1'b0);
      chk("t6_err", eo[0], 1'b1);
      tick();
      chk("t6_err_sticky", eo[0], 1'b1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("t6_err_clr", eo[0], 1'b0);

      // reset asserted mid-ACK: no pop, byte consumed after release
      push(8'h34);
      tick();
      chk("t6r_in_ack", nd[0], 1'b0);
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("t6r_nd_async", nd[0], 1'b1);
      check_all();
      #2 rst = 1'b0;
      tick();
      chk("t6r_fifo_kept", q.size(), 1);
      drain();
      chk("t6r_code", kc[0], 8'h34);
      chk("t6r_cnt", pc[0], 4'd1);

      // randomized byte stream
      for (int i = 0; i < 300; i++) begin
         push(pool[$urandom_range(0, 9)]);
         if ($urandom_range(0, 24) == 0) overflow = 1'b1;
         if ($urandom_range(0, 9) == 0) err_clr = 1'b1;
         tick();
         overflow = 1'b0;
         err_clr = 1'b0;
         repeat ($urandom_range(0, 2)) tick();
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
